// File: rtl/pc_redirect_controller.sv
// Purpose : owns the fetch PC. Taken branch/jump redirects load the target PC
//           (misaligned targets trap to TRAP_PC). Each redirect squashes IF/ID
//           and ID/EX for FLUSH_CYCLES cycles. Otherwise the PC advances by 4,
//           or holds while STALL is high.
// Latency : PC, INSTR_VALID and MISALIGN_* are registered (1 cycle).
//           FLUSH_* and PC_PLUS4 are combinational.
// Backpressure: STALL holds PC and INSTR_VALID. A redirect overrides STALL,
//           and the flush countdown keeps running during a stall.
// Ports   : CLK, RESET (async, active-high), STALL, REDIRECT_EN, REDIRECT_PC[31:0]
//           -> PC[31:0], PC_PLUS4[31:0], FLUSH_IF_ID, FLUSH_ID_EX, INSTR_VALID,
//              MISALIGN_EXC, MISALIGN_ADDR[31:0], REDIRECT_COUNT[31:0]
// Option  : define PC_REDIRECT_STATS_EN to build a saturating redirect counter.
//           Without it, REDIRECT_COUNT is tied to 0.
module pc_redirect_controller #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC      = 32'h0000_0100,
  parameter int unsigned FLUSH_CYCLES = 1              // legal 1..4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        REDIRECT_EN,
  input  logic [31:0] REDIRECT_PC,
  output logic [31:0] PC,
  output logic [31:0] PC_PLUS4,
  output logic        FLUSH_IF_ID,
  output logic        FLUSH_ID_EX,
  output logic        INSTR_VALID,
  output logic        MISALIGN_EXC,
  output logic [31:0] MISALIGN_ADDR,
  output logic [31:0] REDIRECT_COUNT
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  // Extra flush cycles after the accepting cycle (at most 3).
  localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic        exc_q, exc_d;
  logic [31:0] maddr_q, maddr_d;
  logic [0:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        accept;
  logic        misaligned;

  // The redirecting instruction is older than anything stalled, so it wins.
  assign accept     = REDIRECT_EN & ~RESET;
  assign misaligned = (REDIRECT_PC[1:0] != 2'b00);
  assign PC_PLUS4   = pc_q + 32'd4;

  // The bubble is written on the same edge that loads the new PC.
  assign FLUSH_IF_ID = accept | (state_q == ST_FLUSH);
  assign FLUSH_ID_EX = accept | (state_q == ST_FLUSH);

  always_comb begin
    pc_d    = pc_q;
    valid_d = valid_q;
    exc_d   = 1'b0;
    maddr_d = maddr_q;
    state_d = state_q;
    cnt_d   = cnt_q;

    if (accept) begin
      if (misaligned) begin
        pc_d    = TRAP_PC;
        exc_d   = 1'b1;
        maddr_d = REDIRECT_PC;
      end else begin
        pc_d    = REDIRECT_PC;
      end
      valid_d = 1'b1;
      // A redirect during FLUSH restarts the full window.
      if (FLUSH_CYCLES > 1) begin
        state_d = ST_FLUSH;
        cnt_d   = CNT_LOAD;
      end else begin
        state_d = ST_RUN;
        cnt_d   = 3'd0;
      end
    end else begin
      if (!STALL) begin
        pc_d    = PC_PLUS4;
        valid_d = 1'b1;
      end
      // The flush countdown is independent of STALL.
      if (state_q == ST_FLUSH) begin
        if (cnt_q <= 3'd1) begin
          state_d = ST_RUN;
          cnt_d   = 3'd0;
        end else begin
          cnt_d   = cnt_q - 3'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      exc_q   <= 1'b0;
      maddr_q <= 32'd0;
      state_q <= ST_RUN;
      cnt_q   <= 3'd0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      exc_q   <= exc_d;
      maddr_q <= maddr_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PC            = pc_q;
  assign INSTR_VALID   = valid_q;
  assign MISALIGN_EXC  = exc_q;
  assign MISALIGN_ADDR = maddr_q;

`ifdef PC_REDIRECT_STATS_EN
  logic [31:0] redir_cnt_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      redir_cnt_q <= 32'd0;
    end else if (accept && (redir_cnt_q != 32'hFFFF_FFFF)) begin
      redir_cnt_q <= redir_cnt_q + 32'd1;
    end
  end

  assign REDIRECT_COUNT = redir_cnt_q;
`else
  assign REDIRECT_COUNT = 32'd0;
`endif

endmodule

// File: tb/tb_pc_redirect_controller.sv
// Directed test of pc_redirect_controller. Three instances (FLUSH_CYCLES = 1, 3, 4)
// share all inputs. PC behaviour does not depend on FLUSH_CYCLES, so one table row
// holds the common expectations plus one flush bit per instance.
module tb_pc_redirect_controller;

  logic        CLK;
  logic        RESET;
  logic        STALL;
  logic        REDIRECT_EN;
  logic [31:0] REDIRECT_PC;

  logic [31:0] pc_w    [3];
  logic [31:0] plus4_w [3];
  logic        fifid_w [3];
  logic        fidex_w [3];
  logic        valid_w [3];
  logic        exc_w   [3];
  logic [31:0] maddr_w [3];
  logic [31:0] rcnt_w  [3];

  pc_redirect_controller #(.FLUSH_CYCLES(1)) u_fc1 (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .REDIRECT_EN(REDIRECT_EN),
    .REDIRECT_PC(REDIRECT_PC), .PC(pc_w[0]), .PC_PLUS4(plus4_w[0]),
    .FLUSH_IF_ID(fifid_w[0]), .FLUSH_ID_EX(fidex_w[0]), .INSTR_VALID(valid_w[0]),
    .MISALIGN_EXC(exc_w[0]), .MISALIGN_ADDR(maddr_w[0]), .REDIRECT_COUNT(rcnt_w[0]));

  pc_redirect_controller #(.FLUSH_CYCLES(3)) u_fc3 (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .REDIRECT_EN(REDIRECT_EN),
    .REDIRECT_PC(REDIRECT_PC), .PC(pc_w[1]), .PC_PLUS4(plus4_w[1]),
    .FLUSH_IF_ID(fifid_w[1]), .FLUSH_ID_EX(fidex_w[1]), .INSTR_VALID(valid_w[1]),
    .MISALIGN_EXC(exc_w[1]), .MISALIGN_ADDR(maddr_w[1]), .REDIRECT_COUNT(rcnt_w[1]));

  pc_redirect_controller #(.FLUSH_CYCLES(4)) u_fc4 (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .REDIRECT_EN(REDIRECT_EN),
    .REDIRECT_PC(REDIRECT_PC), .PC(pc_w[2]), .PC_PLUS4(plus4_w[2]),
    .FLUSH_IF_ID(fifid_w[2]), .FLUSH_ID_EX(fidex_w[2]), .INSTR_VALID(valid_w[2]),
    .MISALIGN_EXC(exc_w[2]), .MISALIGN_ADDR(maddr_w[2]), .REDIRECT_COUNT(rcnt_w[2]));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int          row;
    logic [31:0] pc;
    logic        valid;
    logic        exc;
    logic [31:0] maddr;
    logic [31:0] cnt;
    logic [2:0]  fl;   // {FC1, FC3, FC4}
  } exp_t;

  exp_t exp_q[$];
  event chk_ev;
  int   checks   = 0;
  int   failures = 0;
  int   row_no   = 0;

  task automatic chk(input int row, input string name, input int inst,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL row%0d %s fc_inst%0d actual=%h required=%h", row, name, inst, act, req);
    end
  endtask

  // Monitor: pops one expectation per sample event and compares all instances.
  initial begin
    forever begin
      @(chk_ev);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_underflow actual=0 required=1");
      end else begin
        exp_t e;
        logic [31:0] cnt_req;
        e = exp_q.pop_front();
`ifdef PC_REDIRECT_STATS_EN
        cnt_req = e.cnt;
`else
        cnt_req = 32'd0;
`endif
        for (int i = 0; i < 3; i++) begin
          chk(e.row, "pc",     i, pc_w[i],           e.pc);
          chk(e.row, "pc4",    i, plus4_w[i],        e.pc + 32'd4);
          chk(e.row, "valid",  i, {31'd0, valid_w[i]}, {31'd0, e.valid});
          chk(e.row, "exc",    i, {31'd0, exc_w[i]},   {31'd0, e.exc});
          chk(e.row, "maddr",  i, maddr_w[i],        e.maddr);
          chk(e.row, "rcount", i, rcnt_w[i],         cnt_req);
          chk(e.row, "fl_ifid", i, {31'd0, fifid_w[i]}, {31'd0, e.fl[2-i]});
          chk(e.row, "fl_idex", i, {31'd0, fidex_w[i]}, {31'd0, e.fl[2-i]});
        end
      end
    end
  end

  // Drive inputs now, queue the expected outputs, sample 1 time unit later.
  task automatic apply(input logic rst, input logic stl, input logic en,
                       input logic [31:0] rpc, input logic [31:0] pc,
                       input logic vld, input logic exc, input logic [31:0] maddr,
                       input logic [31:0] cnt, input logic [2:0] fl);
    exp_t e;
    RESET       = rst;
    STALL       = stl;
    REDIRECT_EN = en;
    REDIRECT_PC = rpc;
    e.row = row_no; e.pc = pc; e.valid = vld; e.exc = exc;
    e.maddr = maddr; e.cnt = cnt; e.fl = fl;
    exp_q.push_back(e);
    row_no++;
    #1;
    ->chk_ev;
  endtask

  task automatic step(input logic rst, input logic stl, input logic en,
                      input logic [31:0] rpc, input logic [31:0] pc,
                      input logic vld, input logic exc, input logic [31:0] maddr,
                      input logic [31:0] cnt, input logic [2:0] fl);
    @(negedge CLK);
    apply(rst, stl, en, rpc, pc, vld, exc, maddr, cnt, fl);
  endtask

  initial begin
    RESET = 1'b1; STALL = 1'b0; REDIRECT_EN = 1'b0; REDIRECT_PC = 32'd0;
    //     rst stl en  rpc            pc            v  exc maddr    cnt fl{1,3,4}
    step(1, 0, 1, 32'h40,  32'h0,   0, 0, 32'h0,   0, 3'b000); // 0 reset gates flush
    step(0, 0, 0, 32'h0,   32'h0,   0, 0, 32'h0,   0, 3'b000); // 1
    step(0, 0, 0, 32'h0,   32'h4,   1, 0, 32'h0,   0, 3'b000); // 2
    step(0, 0, 0, 32'h0,   32'h8,   1, 0, 32'h0,   0, 3'b000); // 3
    step(0, 0, 0, 32'h0,   32'hC,   1, 0, 32'h0,   0, 3'b000); // 4
    step(0, 0, 1, 32'h40,  32'h10,  1, 0, 32'h0,   0, 3'b111); // 5 redirect 0x40
    step(0, 0, 0, 32'h0,   32'h40,  1, 0, 32'h0,   1, 3'b011); // 6
    step(0, 0, 0, 32'h0,   32'h44,  1, 0, 32'h0,   1, 3'b011); // 7
    step(0, 0, 0, 32'h0,   32'h48,  1, 0, 32'h0,   1, 3'b001); // 8
    step(0, 0, 0, 32'h0,   32'h4C,  1, 0, 32'h0,   1, 3'b000); // 9
    step(0, 0, 1, 32'h80,  32'h50,  1, 0, 32'h0,   1, 3'b111); // 10 redirect 0x80
    step(0, 0, 1, 32'hC0,  32'h80,  1, 0, 32'h0,   2, 3'b111); // 11 redirect 0xC0 restarts
    step(0, 0, 0, 32'h0,   32'hC0,  1, 0, 32'h0,   3, 3'b011); // 12
    step(0, 0, 0, 32'h0,   32'hC4,  1, 0, 32'h0,   3, 3'b011); // 13
    step(0, 0, 0, 32'h0,   32'hC8,  1, 0, 32'h0,   3, 3'b001); // 14
    step(0, 1, 1, 32'h200, 32'hCC,  1, 0, 32'h0,   3, 3'b111); // 15 redirect beats stall
    step(0, 1, 0, 32'h0,   32'h200, 1, 0, 32'h0,   4, 3'b011); // 16 stall holds
    step(0, 1, 0, 32'h0,   32'h200, 1, 0, 32'h0,   4, 3'b011); // 17 stall holds
    step(0, 0, 0, 32'h0,   32'h200, 1, 0, 32'h0,   4, 3'b001); // 18
    step(0, 0, 1, 32'h102, 32'h204, 1, 0, 32'h0,   4, 3'b111); // 19 misaligned
    step(0, 0, 0, 32'h0,   32'h100, 1, 1, 32'h102, 5, 3'b011); // 20 trap, exc pulse
    step(0, 0, 0, 32'h0,   32'h104, 1, 0, 32'h102, 5, 3'b011); // 21 exc gone
    step(0, 0, 0, 32'h0,   32'h108, 1, 0, 32'h102, 5, 3'b001); // 22
    step(0, 0, 1, 32'h1,   32'h10C, 1, 0, 32'h102, 5, 3'b111); // 23 misaligned
    step(0, 0, 1, 32'h3,   32'h100, 1, 1, 32'h1,   6, 3'b111); // 24 back-to-back
    step(0, 0, 0, 32'h0,   32'h100, 1, 1, 32'h3,   7, 3'b011); // 25 FC4 2nd flush cycle
    apply(1, 0, 0, 32'h0,  32'h0,   0, 0, 32'h0,   0, 3'b000); // 26 async reset, no edge
    step(1, 0, 0, 32'h0,   32'h0,   0, 0, 32'h0,   0, 3'b000); // 27
    step(0, 0, 0, 32'h0,   32'h0,   0, 0, 32'h0,   0, 3'b000); // 28 release
    step(0, 0, 0, 32'h0,   32'h4,   1, 0, 32'h0,   0, 3'b000); // 29
    step(0, 0, 0, 32'h0,   32'h8,   1, 0, 32'h0,   0, 3'b000); // 30
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
